// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller_pkg
// Description : Shared CPU types and constants for the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_controller_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        VEC_BUSY = 1'b1
    } state_t;

    localparam logic [4:0] C_ZERO_REG = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller_if
// Description : Decode/execute hazard inputs and pipeline control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_controller_if #(
    parameter int VEC_LAT_W = 3,
    parameter int PERF_W    = 16
);
    logic [4:0]           rs1_decode;
    logic [4:0]           rs2_decode;
    logic [4:0]           rd_execute;
    logic                 load_instruction;
    logic                 load_vector_execute;
    logic                 vector_start_execute;
    logic [VEC_LAT_W-1:0] vector_latency_execute;
    logic                 branch_taken_execute;
    logic                 stall_fetch;
    logic                 stall_decode;
    logic                 nop_select;
    logic                 flush_decode;
    logic                 vector_busy;
    logic [PERF_W-1:0]    stall_cycles;

    modport master (
        output rs1_decode, rs2_decode, rd_execute, load_instruction,
               load_vector_execute, vector_start_execute,
               vector_latency_execute, branch_taken_execute,
        input  stall_fetch, stall_decode, nop_select, flush_decode,
               vector_busy, stall_cycles
    );

    modport slave (
        input  rs1_decode, rs2_decode, rd_execute, load_instruction,
               load_vector_execute, vector_start_execute,
               vector_latency_execute, branch_taken_execute,
        output stall_fetch, stall_decode, nop_select, flush_decode,
               vector_busy, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detector
// Description : Combinational load-use compare between execute and decode.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detector
    import pipeline_hazard_controller_pkg::*;
(
    input  wire logic [4:0] i_rs1,
    input  wire logic [4:0] i_rs2,
    input  wire logic [4:0] i_rd,
    input  wire logic       i_load_scalar,
    input  wire logic       i_load_vector,
    output logic            o_hazard
);
    // x0 never carries a real dependency, so it is excluded from the match
    assign o_hazard = (i_load_scalar || i_load_vector) &&
                      (i_rd != C_ZERO_REG) &&
                      ((i_rd == i_rs1) || (i_rd == i_rs2));
endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Load-use stall, branch flush and vector-occupancy control.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int VEC_LAT_W = 3,
    parameter int PERF_W    = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    pipeline_hazard_controller_if.slave bus
);
    state_t               r_state;
    logic [VEC_LAT_W-1:0] r_vec_cnt;
    logic [PERF_W-1:0]    r_stall_cycles;

    logic w_hazard;
    logic w_vec_long;
    logic w_stall;
    logic w_nop;
    logic w_flush;
    logic w_busy;

    load_use_detector u_load_use_detector (
        .i_rs1         (bus.rs1_decode),
        .i_rs2         (bus.rs2_decode),
        .i_rd          (bus.rd_execute),
        .i_load_scalar (bus.load_instruction),
        .i_load_vector (bus.load_vector_execute),
        .o_hazard      (w_hazard)
    );

    assign w_vec_long = bus.vector_start_execute &&
                        (bus.vector_latency_execute > VEC_LAT_W'(1));

    // Priority in IDLE: branch flush, then vector launch, then load-use bubble
    always_comb begin
        w_stall = 1'b0;
        w_nop   = 1'b0;
        w_flush = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.branch_taken_execute) begin
                    w_flush = 1'b1;
                    w_nop   = 1'b1;
                end else if (w_vec_long) begin
                    w_stall = 1'b1;
                    w_busy  = 1'b1;
                end else if (w_hazard) begin
                    w_stall = 1'b1;
                    w_nop   = 1'b1;
                end
            end
            VEC_BUSY: begin
                w_stall = 1'b1;
                w_busy  = 1'b1;
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_vec_cnt      <= '0;
            r_stall_cycles <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!bus.branch_taken_execute && w_vec_long) begin
                        r_state   <= VEC_BUSY;
                        r_vec_cnt <= bus.vector_latency_execute - VEC_LAT_W'(2);
                    end
                end
                VEC_BUSY: begin
                    if (r_vec_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_vec_cnt <= r_vec_cnt - VEC_LAT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_stall && (r_stall_cycles != {PERF_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            end
        end
    end

    // Outputs are forced low for the whole time reset is held
    assign bus.stall_fetch  = w_stall & ~reset;
    assign bus.stall_decode = w_stall & ~reset;
    assign bus.nop_select   = w_nop   & ~reset;
    assign bus.flush_decode = w_flush & ~reset;
    assign bus.vector_busy  = w_busy  & ~reset;
    assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Randomized + directed bench against a cycle-count reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.VEC_LAT_W(3), .PERF_W(16)) bus16 ();
    pipeline_hazard_controller_if #(.VEC_LAT_W(3), .PERF_W(4))  bus4 ();

    assign bus4.rs1_decode             = bus16.rs1_decode;
    assign bus4.rs2_decode             = bus16.rs2_decode;
    assign bus4.rd_execute             = bus16.rd_execute;
    assign bus4.load_instruction       = bus16.load_instruction;
    assign bus4.load_vector_execute    = bus16.load_vector_execute;
    assign bus4.vector_start_execute   = bus16.vector_start_execute;
    assign bus4.vector_latency_execute = bus16.vector_latency_execute;
    assign bus4.branch_taken_execute   = bus16.branch_taken_execute;

    pipeline_hazard_controller #(.VEC_LAT_W(3), .PERF_W(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    pipeline_hazard_controller #(.VEC_LAT_W(3), .PERF_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: cycles of vector occupancy still to come, and total stall cycles
    int m_remaining = 0;
    int m_stalls    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit ld, input bit vld, input bit vs,
                        input logic [2:0] lat, input bit br);
        bit e_stall, e_nop, e_flush, e_busy;
        reset                              = rst;
        bus16.rs1_decode                   = rs1;
        bus16.rs2_decode                   = rs2;
        bus16.rd_execute                   = rd;
        bus16.load_instruction             = ld;
        bus16.load_vector_execute          = vld;
        bus16.vector_start_execute         = vs;
        bus16.vector_latency_execute       = lat;
        bus16.branch_taken_execute         = br;
        #4;
        e_stall = 1'b0; e_nop = 1'b0; e_flush = 1'b0; e_busy = 1'b0;
        if (!rst) begin
            if (m_remaining > 0) begin
                e_stall = 1'b1; e_busy = 1'b1;
            end else if (br) begin
                e_flush = 1'b1; e_nop = 1'b1;
            end else if (vs && lat >= 2) begin
                e_stall = 1'b1; e_busy = 1'b1;
            end else if ((ld || vld) && rd != 0 && (rd == rs1 || rd == rs2)) begin
                e_stall = 1'b1; e_nop = 1'b1;
            end
        end
        check("stall_fetch",  bus16.stall_fetch,  e_stall);
        check("stall_decode", bus16.stall_decode, e_stall);
        check("nop_select",   bus16.nop_select,   e_nop);
        check("flush_decode", bus16.flush_decode, e_flush);
        check("vector_busy",  bus16.vector_busy,  e_busy);
        check("stall_cycles16", bus16.stall_cycles, rst ? 0 : sat(m_stalls, 65535));
        check("stall_cycles4",  bus4.stall_cycles,  rst ? 0 : sat(m_stalls, 15));
        check("stall_fetch4",   bus4.stall_fetch,   e_stall);
        @(posedge clk);
        if (rst) begin
            m_remaining = 0;
            m_stalls    = 0;
        end else begin
            if (m_remaining > 0)            m_remaining--;
            else if (!br && vs && lat >= 2) m_remaining = lat - 1;
            m_stalls += int'(e_stall);
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Reset holds outputs low even with a hazard and a branch presented
        step(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        step(1'b1, 5'd3, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0);

        // Scalar load-use bubble
        step(1'b0, 5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        idle();
        check("stall_cnt_after_load", bus16.stall_cycles, 1);
        // x0 destination never stalls
        step(1'b0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        // Vector load hazard on rs2
        step(1'b0, 5'd1, 5'd12, 5'd12, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

        // Latency-4 vector op: busy for exactly 4 cycles
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
        step(1'b0, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        idle(); idle(); idle();
        check("stall_cnt_after_vec4", bus16.stall_cycles, 6);

        // Branch wins over a simultaneous load-use hazard
        step(1'b0, 5'd8, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        // Short vector ops do not stall
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        idle(); idle();

        // Asynchronous reset in the 2nd VEC_BUSY cycle of a latency-6 op
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
        idle();
        bus16.vector_start_execute = 1'b0;
        #2;
        check("busy_before_async_rst", bus16.vector_busy, 1'b1);
        reset = 1'b1;
        #1;
        check("async_rst_busy",  bus16.vector_busy,  1'b0);
        check("async_rst_stall", bus16.stall_fetch,  1'b0);
        check("async_rst_cnt",   bus16.stall_cycles, 0);
        @(posedge clk);
        m_remaining = 0;
        m_stalls    = 0;
        #1;
        idle();
        check("post_rst_busy", bus16.vector_busy, 1'b0);
        idle();

        // Saturate the narrow counter with 21 back-to-back stall cycles
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
            for (int j = 0; j < 6; j++) idle();
        end
        check("sat_stall_cycles4", bus4.stall_cycles, 15);
        idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 59) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
